// File: rtl/ahb_vga_pkg.sv
// rtl/ahb_vga_pkg.sv - region types, entry layout and address map for the AHB VGA write buffer
package ahb_vga_pkg;

    typedef enum logic [1:0] {
        RGN_CONSOLE = 2'd0,
        RGN_IMAGE   = 2'd1,
        RGN_REGS    = 2'd2
    } region_e;

    // Queue entry field widths; the top-level IMG_AW/DATA_W defaults track these
    localparam int WBUF_IMG_AW = 14;
    localparam int WBUF_DATA_W = 8;

    localparam logic [23:0] CONSOLE_OFS = 24'h000000;
    localparam logic [23:0] REGS_BASE   = 24'hFFFFF0;
    localparam logic [23:0] STATS_OFS   = 24'hFFFFF8;
    localparam logic [23:0] STATUS_OFS  = 24'hFFFFFC;

    typedef struct packed {
        region_e                region;
        logic [WBUF_IMG_AW-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

    function automatic region_e decode_region(input logic [23:0] ofs);
        if (ofs == CONSOLE_OFS) return RGN_CONSOLE;
        if (ofs >= REGS_BASE) return RGN_REGS;
        return RGN_IMAGE;
    endfunction

    // Status register shows at most 15 entries in its 4-bit count field
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/ahb_vga_wfifo.sv
// rtl/ahb_vga_wfifo.sv - synchronous write queue with occupancy count
module ahb_vga_wfifo
    import ahb_vga_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: guarded push/pop, power-of-two pointers wrap naturally
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointers; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ahb_vga_wbuf.sv
// rtl/ahb_vga_wbuf.sv - AHB-Lite slave queueing console/image writes for the VGA subsystem
// Optional stall counter at 0xFFFFF8: define AHBVGA_WBUF_STATS_EN.
module ahb_vga_wbuf
    import ahb_vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int IMG_AW     = WBUF_IMG_AW,
    parameter int DATA_W     = WBUF_DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic              scroll_i,
    output logic              console_we,
    output logic [DATA_W-1:0] console_wdata,
    output logic              image_we,
    output logic [IMG_AW-1:0] image_addr,
    output logic [DATA_W-1:0] image_wdata
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(wbuf_entry_t);

    logic              dph_valid_q, dph_valid_d;
    logic              dph_write_q, dph_write_d;
    region_e           dph_rgn_q, dph_rgn_d;
    logic [23:0]       dph_ofs_q, dph_ofs_d;

    logic              console_we_q, console_we_d;
    logic [DATA_W-1:0] console_wdata_q, console_wdata_d;
    logic              image_we_q, image_we_d;
    logic [IMG_AW-1:0] image_addr_q, image_addr_d;
    logic [DATA_W-1:0] image_wdata_q, image_wdata_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_dout;
    wbuf_entry_t       push_entry, head_entry;

    logic              wr_to_fifo;
    logic              hready_out;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign unused_bits = ^{HADDR[31:24], HTRANS[0], HWDATA[31:DATA_W]};

    ahb_vga_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wfifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Address phase capture; held while a stalled data phase keeps HREADY low
    always_comb begin
        dph_valid_d = dph_valid_q;
        dph_write_d = dph_write_q;
        dph_rgn_d   = dph_rgn_q;
        dph_ofs_d   = dph_ofs_q;
        if (HREADY) begin
            dph_valid_d = HSEL & HTRANS[1];
            dph_write_d = HWRITE;
            dph_rgn_d   = decode_region(HADDR[23:0]);
            dph_ofs_d   = HADDR[23:0];
        end
    end

    // Data-phase write: queue console/image writes, stall only while the queue is full
    always_comb begin
        wr_to_fifo        = dph_valid_q & dph_write_q & (dph_rgn_q != RGN_REGS);
        hready_out        = ~(wr_to_fifo & fifo_full);
        fifo_push         = wr_to_fifo & ~fifo_full;
        push_entry.region = dph_rgn_q;
        push_entry.addr   = (dph_rgn_q == RGN_IMAGE) ? dph_ofs_q[IMG_AW+1:2] : '0;
        push_entry.data   = HWDATA[DATA_W-1:0];
    end

    // In-order drain: a console head waits out scrolling and blocks everything behind it
    always_comb begin
        head_entry      = wbuf_entry_t'(fifo_dout);
        fifo_pop        = ~fifo_empty & ((head_entry.region == RGN_IMAGE) | ~scroll_i);
        console_we_d    = fifo_pop & (head_entry.region == RGN_CONSOLE);
        image_we_d      = fifo_pop & (head_entry.region == RGN_IMAGE);
        console_wdata_d = console_we_d ? head_entry.data : console_wdata_q;
        image_addr_d    = image_we_d ? head_entry.addr : image_addr_q;
        image_wdata_d   = image_we_d ? head_entry.data : image_wdata_q;
    end

`ifdef AHBVGA_WBUF_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled bus cycles; any write to its address clears it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (dph_valid_q && dph_write_q && (dph_ofs_q == STATS_OFS)) begin
            stall_cnt_d = '0;
        end else if (!hready_out && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end
`endif

    // Zero-wait read mux over the register window
    always_comb begin
        rd_data = '0;
        if (dph_valid_q && !dph_write_q) begin
            if (dph_ofs_q == STATUS_OFS) begin
                rd_data = 32'({fifo_full, fifo_empty, scroll_i, sat_count4(32'(fifo_count))});
            end
`ifdef AHBVGA_WBUF_STATS_EN
            if (dph_ofs_q == STATS_OFS) begin
                rd_data = {16'h0, stall_cnt_q};
            end
`endif
        end
    end

    // Bus-phase and registered write-port state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_valid_q     <= 1'b0;
            dph_write_q     <= 1'b0;
            dph_rgn_q       <= RGN_CONSOLE;
            dph_ofs_q       <= '0;
            console_we_q    <= 1'b0;
            console_wdata_q <= '0;
            image_we_q      <= 1'b0;
            image_addr_q    <= '0;
            image_wdata_q   <= '0;
        end else begin
            dph_valid_q     <= dph_valid_d;
            dph_write_q     <= dph_write_d;
            dph_rgn_q       <= dph_rgn_d;
            dph_ofs_q       <= dph_ofs_d;
            console_we_q    <= console_we_d;
            console_wdata_q <= console_wdata_d;
            image_we_q      <= image_we_d;
            image_addr_q    <= image_addr_d;
            image_wdata_q   <= image_wdata_d;
        end
    end

    assign HREADYOUT     = hready_out;
    assign HRDATA        = rd_data;
    assign console_we    = console_we_q;
    assign console_wdata = console_wdata_q;
    assign image_we      = image_we_q;
    assign image_addr    = image_addr_q;
    assign image_wdata   = image_wdata_q;

endmodule
